pic_int_sequencer: RTL and testbench

- Interrupt acknowledge sequencer and priority resolver for the PIC8259 core.
- Sits between the request register (IRR), the mask register (IMR) and the in-service register (ISR).
- Raises INT, runs the two-pulse INTA cycle, sets and clears ISR bits, and drives the interrupt vector onto the data bus.
- Owns the ISR storage and replaces the standalone combinational ISR update.

---
 rtl/pic_int_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_pic_int_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic_int_sequencer.sv
// ----------------------------------------------------------------------------
// pic_int_sequencer
//
// Interrupt acknowledge sequencer and fixed-priority resolver for the PIC8259
// core. It arbitrates pending requests (irr & ~imr) against the in-service
// register and raises INT. It then runs the two-pulse INTA cycle, owns the
// ISR storage, and places the interrupt vector on the data bus.
//
// Parameters
//   AEOI        : 1 = ISR bit is cleared automatically on the second INTA.
//
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   irr[7:0]    : latched interrupt requests (bit 0 = IR0, highest priority)
//   imr[7:0]    : interrupt mask (1 = masked)
//   inta        : synchronised one-cycle INTA strobe
//   eoi         : one-cycle non-specific EOI command
//   seoi        : one-cycle specific EOI command
//   seoi_level  : level cleared by seoi
//   vector_base : ICW2 bits T7..T3
//   INT         : interrupt request to the CPU
//   ISR[7:0]    : in-service register
//   irr_clr[7:0]: one-hot, one-cycle pulse clearing the acknowledged IRR bit
//   data_out    : vector byte {vector_base, level}
//   data_oe     : one-cycle valid/drive enable for data_out
// ----------------------------------------------------------------------------
module pic_int_sequencer #(
    parameter bit AEOI = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       inta,
    input  logic       eoi,
    input  logic       seoi,
    input  logic [2:0] seoi_level,
    input  logic [4:0] vector_base,
    output logic       INT,
    output logic [7:0] ISR,
    output logic [7:0] irr_clr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Index of the lowest set bit (highest priority); 0 when v is zero, so
    // callers must qualify the result with a non-zero test.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot decode of a 3-bit level.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;

    logic       int_r;
    logic [7:0] isr_r;
    logic [7:0] irr_clr_r;
    logic [7:0] data_out_r;
    logic       data_oe_r;
    logic [2:0] lvl_r;
    logic       spurious_r;

    logic       int_nxt_s;
    logic [7:0] isr_nxt_s;
    logic [7:0] irr_clr_nxt_s;
    logic [7:0] data_out_nxt_s;
    logic       data_oe_nxt_s;
    logic [2:0] lvl_nxt_s;
    logic       spurious_nxt_s;

    logic [7:0] pend_s;
    logic [2:0] win_s;
    logic [2:0] cur_s;
    logic       req_ok_s;
    logic [7:0] eoi_clr_s;
    logic [7:0] isr_set_s;
    logic [7:0] aeoi_clr_s;

    // Priority resolution: the winner must outrank everything in service.
    always_comb begin
        pend_s   = irr & ~imr;
        win_s    = lowest_idx(pend_s);
        cur_s    = lowest_idx(isr_r);
        req_ok_s = (pend_s != 8'h00) && ((isr_r == 8'h00) || (win_s < cur_s));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. Once INT is up the CPU is committed, so REQ waits for
    // inta even when the request has been withdrawn.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_ok_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (inta) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_ACK: begin
                if (inta) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and ISR next-value logic. EOI clears are computed on the old ISR
    // and the acknowledge set is OR-ed in afterwards, so a set wins a collision.
    always_comb begin
        int_nxt_s      = int_r;
        irr_clr_nxt_s  = 8'h00;
        data_out_nxt_s = data_out_r;
        data_oe_nxt_s  = 1'b0;
        lvl_nxt_s      = lvl_r;
        spurious_nxt_s = spurious_r;
        isr_set_s      = 8'h00;
        aeoi_clr_s     = 8'h00;

        if (eoi && (isr_r != 8'h00)) begin
            eoi_clr_s = onehot8(cur_s);
        end else begin
            eoi_clr_s = 8'h00;
        end
        if (seoi) begin
            eoi_clr_s = eoi_clr_s | onehot8(seoi_level);
        end else begin
            eoi_clr_s = eoi_clr_s;
        end

        case (state_r)
            ST_IDLE: begin
                int_nxt_s = req_ok_s;
            end
            ST_REQ: begin
                int_nxt_s = 1'b1;
                if (inta && req_ok_s) begin
                    lvl_nxt_s      = win_s;
                    spurious_nxt_s = 1'b0;
                    isr_set_s      = onehot8(win_s);
                    irr_clr_nxt_s  = onehot8(win_s);
                end else if (inta) begin
                    // Request withdrawn before the first INTA: answer IR7.
                    lvl_nxt_s      = 3'd7;
                    spurious_nxt_s = 1'b1;
                end else begin
                    lvl_nxt_s      = lvl_r;
                end
            end
            ST_ACK: begin
                if (inta) begin
                    int_nxt_s      = 1'b0;
                    data_out_nxt_s = {vector_base, lvl_r};
                    data_oe_nxt_s  = 1'b1;
                    if (AEOI && !spurious_r) begin
                        aeoi_clr_s = onehot8(lvl_r);
                    end else begin
                        aeoi_clr_s = 8'h00;
                    end
                end else begin
                    int_nxt_s = 1'b1;
                end
            end
            default: begin
                int_nxt_s = 1'b0;
            end
        endcase

        isr_nxt_s = ((isr_r & ~eoi_clr_s) | isr_set_s) & ~aeoi_clr_s;
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_r      <= 1'b0;
            isr_r      <= 8'h00;
            irr_clr_r  <= 8'h00;
            data_out_r <= 8'h00;
            data_oe_r  <= 1'b0;
            lvl_r      <= 3'd0;
            spurious_r <= 1'b0;
        end else begin
            int_r      <= int_nxt_s;
            isr_r      <= isr_nxt_s;
            irr_clr_r  <= irr_clr_nxt_s;
            data_out_r <= data_out_nxt_s;
            data_oe_r  <= data_oe_nxt_s;
            lvl_r      <= lvl_nxt_s;
            spurious_r <= spurious_nxt_s;
        end
    end

    assign INT      = int_r;
    assign ISR      = isr_r;
    assign irr_clr  = irr_clr_r;
    assign data_out = data_out_r;
    assign data_oe  = data_oe_r;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pic_int_sequencer
//
// Directed bench for pic_int_sequencer. One instance is built with AEOI=0 and
// one with AEOI=1. Inputs change 1 time unit after a rising edge, and
// outputs are sampled at that same point, after the registers have updated.
// ----------------------------------------------------------------------------
module tb_pic_int_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] irr, imr;
    logic       inta, eoi, seoi;
    logic [2:0] seoi_level;
    logic [4:0] vector_base;
    logic       int_o;
    logic [7:0] isr_o, irr_clr_o, data_out_o;
    logic       data_oe_o;

    logic [7:0] irr_a;
    logic       inta_a;
    logic       int_a;
    logic [7:0] isr_a, irr_clr_a, data_out_a;
    logic       data_oe_a;

    int total;
    int bad;

    pic_int_sequencer #(.AEOI(1'b0)) dut (
        .clk(clk), .rst(rst), .irr(irr), .imr(imr), .inta(inta), .eoi(eoi),
        .seoi(seoi), .seoi_level(seoi_level), .vector_base(vector_base),
        .INT(int_o), .ISR(isr_o), .irr_clr(irr_clr_o), .data_out(data_out_o),
        .data_oe(data_oe_o)
    );

    pic_int_sequencer #(.AEOI(1'b1)) dut_aeoi (
        .clk(clk), .rst(rst), .irr(irr_a), .imr(8'h00), .inta(inta_a), .eoi(1'b0),
        .seoi(1'b0), .seoi_level(3'd0), .vector_base(5'b01000),
        .INT(int_a), .ISR(isr_a), .irr_clr(irr_clr_a), .data_out(data_out_a),
        .data_oe(data_oe_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; irr = 8'h00; imr = 8'h00; inta = 1'b0; eoi = 1'b0;
        seoi = 1'b0; seoi_level = 3'd0; vector_base = 5'b01000;
        irr_a = 8'h00; inta_a = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_int", {7'd0, int_o}, 8'h00);
        chk("rst_isr", isr_o, 8'h00);
        chk("rst_irr_clr", irr_clr_o, 8'h00);
        chk("rst_data_out", data_out_o, 8'h00);
        chk("rst_data_oe", {7'd0, data_oe_o}, 8'h00);

        // Basic cycle on IR3
        irr = 8'h08;
        tick();
        chk("basic_int", {7'd0, int_o}, 8'h01);
        pulse_inta();
        irr = 8'h00;
        chk("basic_isr", isr_o, 8'h08);
        chk("basic_irr_clr", irr_clr_o, 8'h08);
        tick();
        chk("basic_irr_clr_off", irr_clr_o, 8'h00);
        chk("basic_int_held", {7'd0, int_o}, 8'h01);
        pulse_inta();
        chk("basic_vec", data_out_o, 8'h43);
        chk("basic_oe", {7'd0, data_oe_o}, 8'h01);
        chk("basic_int_low", {7'd0, int_o}, 8'h00);
        tick();
        chk("basic_oe_off", {7'd0, data_oe_o}, 8'h00);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("basic_eoi", isr_o, 8'h00);

        // Priority and nesting: IR3 in service
        irr = 8'h08;
        tick();
        pulse_inta();
        irr = 8'h00;
        pulse_inta();
        chk("nest_isr3", isr_o, 8'h08);
        irr = 8'h30;
        tick();
        tick();
        chk("nest_low_held", {7'd0, int_o}, 8'h00);
        irr = 8'h32;
        tick();
        chk("nest_int", {7'd0, int_o}, 8'h01);
        pulse_inta();
        chk("nest_isr", isr_o, 8'h0A);
        chk("nest_irr_clr", irr_clr_o, 8'h02);
        irr = 8'h30;
        pulse_inta();
        chk("nest_vec", data_out_o, 8'h41);
        tick();
        chk("nest_int_off", {7'd0, int_o}, 8'h00);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("nest_eoi", isr_o, 8'h08);
        tick();
        chk("nest_still_held", {7'd0, int_o}, 8'h00);
        irr = 8'h00;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("nest_eoi2", isr_o, 8'h00);

        // Masking
        irr = 8'h01; imr = 8'h01;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mask_int", {7'd0, int_o}, 8'h00);
        end
        imr = 8'h00;
        tick();
        chk("unmask_int", {7'd0, int_o}, 8'h01);
        pulse_inta();
        irr = 8'h00;
        pulse_inta();
        chk("unmask_vec", data_out_o, 8'h40);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("unmask_eoi", isr_o, 8'h00);

        // Spurious: request withdrawn before the first INTA
        irr = 8'h04;
        tick();
        chk("spur_int", {7'd0, int_o}, 8'h01);
        irr = 8'h00;
        tick();
        chk("spur_int_held", {7'd0, int_o}, 8'h01);
        pulse_inta();
        chk("spur_isr", isr_o, 8'h00);
        chk("spur_irr_clr", irr_clr_o, 8'h00);
        pulse_inta();
        chk("spur_vec", data_out_o, 8'h47);
        chk("spur_oe", {7'd0, data_oe_o}, 8'h01);
        chk("spur_isr2", isr_o, 8'h00);
        tick();

        // INTA in IDLE is ignored
        pulse_inta();
        chk("idle_inta_oe", {7'd0, data_oe_o}, 8'h00);
        chk("idle_inta_int", {7'd0, int_o}, 8'h00);

        // EOI coinciding with first INTA: clear old IR2, set IR0
        irr = 8'h04;
        tick();
        pulse_inta();
        irr = 8'h00;
        pulse_inta();
        irr = 8'h01;
        tick();
        chk("eoi_inta_int", {7'd0, int_o}, 8'h01);
        eoi = 1'b1;
        pulse_inta();
        eoi = 1'b0;
        chk("eoi_inta_isr", isr_o, 8'h01);
        irr = 8'h00;
        pulse_inta();
        chk("eoi_inta_vec", data_out_o, 8'h40);
        seoi = 1'b1; seoi_level = 3'd0; tick(); seoi = 1'b0;
        chk("seoi0", isr_o, 8'h00);

        // eoi + seoi together with ISR=05
        irr = 8'h04;
        tick();
        pulse_inta();
        irr = 8'h00;
        pulse_inta();
        irr = 8'h01;
        tick();
        pulse_inta();
        irr = 8'h00;
        pulse_inta();
        chk("both_setup", isr_o, 8'h05);
        eoi = 1'b1; seoi = 1'b1; seoi_level = 3'd2;
        tick();
        eoi = 1'b0; seoi = 1'b0;
        chk("both_clear", isr_o, 8'h00);

        // Reset while in ACK
        irr = 8'h10;
        tick();
        pulse_inta();
        irr = 8'h00;
        chk("ack_isr", isr_o, 8'h10);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("ack_rst_int", {7'd0, int_o}, 8'h00);
        chk("ack_rst_isr", isr_o, 8'h00);
        pulse_inta();
        chk("ack_rst_oe", {7'd0, data_oe_o}, 8'h00);
        chk("ack_rst_int2", {7'd0, int_o}, 8'h00);

        // AEOI instance on IR7
        irr_a = 8'h80;
        tick();
        chk("aeoi_int", {7'd0, int_a}, 8'h01);
        inta_a = 1'b1; tick(); inta_a = 1'b0;
        irr_a = 8'h00;
        chk("aeoi_isr_set", isr_a, 8'h80);
        chk("aeoi_irr_clr", irr_clr_a, 8'h80);
        inta_a = 1'b1; tick(); inta_a = 1'b0;
        chk("aeoi_vec", data_out_a, 8'h47);
        chk("aeoi_oe", {7'd0, data_oe_a}, 8'h01);
        chk("aeoi_isr_clr", isr_a, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
